ibex_ex_issue_ctrl: RTL and testbench

IBEX_EX_ISSUE_CTRL -- requirements
Module: ibex_ex_issue_ctrl

---
 rtl/ibex_ex_issue_ctrl_if.sv | 52 +++++
 rtl/ibex_ex_issue_ctrl.sv | 130 +++++++++++++
 tb/tb_ibex_ex_issue_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ibex_ex_issue_ctrl_if.sv
// ibex_ex_issue_ctrl_if
// Bundles the issue, EX and writeback signals of the EX issue controller.
//   slave  : controller side (ibex_ex_issue_ctrl)
//   master : environment side (decoder / EX / writeback, or a testbench)
// Signal names carry the controller's view of direction (_i = into the controller).
//   issue_valid_i/issue_ready_o, issue_md_i, issue_div_i, issue_tag_i : issue handshake
//   flush_i                                                          : kill in-flight instr
//   alu_instr_first_cycle_o, mult/div_en_o, mult/div_sel_o,
//   multdiv_ready_id_o                                               : EX control
//   ex_valid_i, result_ex_i, imd_val_we_i, imd_val_d_i, imd_val_q_o  : EX results
//   wb_valid_o/wb_ready_i, wb_result_o, wb_tag_o                     : writeback handshake
//   timeout_o                                                        : watchdog pulse
interface ibex_ex_issue_ctrl_if;
  logic             issue_valid_i;
  logic             issue_ready_o;
  logic             issue_md_i;
  logic             issue_div_i;
  logic [4:0]       issue_tag_i;
  logic             flush_i;
  logic             alu_instr_first_cycle_o;
  logic             mult_en_o;
  logic             div_en_o;
  logic             mult_sel_o;
  logic             div_sel_o;
  logic             multdiv_ready_id_o;
  logic             ex_valid_i;
  logic [31:0]      result_ex_i;
  logic [1:0]       imd_val_we_i;
  logic [1:0][33:0] imd_val_d_i;
  logic [1:0][33:0] imd_val_q_o;
  logic             wb_valid_o;
  logic             wb_ready_i;
  logic [31:0]      wb_result_o;
  logic [4:0]       wb_tag_o;
  logic             timeout_o;

  modport slave (
    input  issue_valid_i, issue_md_i, issue_div_i, issue_tag_i, flush_i, ex_valid_i,
           result_ex_i, imd_val_we_i, imd_val_d_i, wb_ready_i,
    output issue_ready_o, alu_instr_first_cycle_o, mult_en_o, div_en_o, mult_sel_o,
           div_sel_o, multdiv_ready_id_o, imd_val_q_o, wb_valid_o, wb_result_o, wb_tag_o,
           timeout_o
  );

  modport master (
    output issue_valid_i, issue_md_i, issue_div_i, issue_tag_i, flush_i, ex_valid_i,
           result_ex_i, imd_val_we_i, imd_val_d_i, wb_ready_i,
    input  issue_ready_o, alu_instr_first_cycle_o, mult_en_o, div_en_o, mult_sel_o,
           div_sel_o, multdiv_ready_id_o, imd_val_q_o, wb_valid_o, wb_result_o, wb_tag_o,
           timeout_o
  );
endinterface

// File: rtl/ibex_ex_issue_ctrl.sv
// ibex_ex_issue_ctrl
// Issue controller for the EX stage: accepts one instruction at a time from the decoder,
// drives the mult/div selects and enables while it executes, buffers the result for
// writeback and aborts instructions that exceed a cycle watchdog.
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset
//   bus   : ibex_ex_issue_ctrl_if.slave (issue, EX control/result, writeback, timeout)
// Parameters: MultDivEn (0 disables mult/div), MaxExCycles (watchdog limit, must be >= 1).
module ibex_ex_issue_ctrl #(
  parameter bit MultDivEn   = 1'b1,
  parameter int MaxExCycles = 40
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  ibex_ex_issue_ctrl_if.slave   bus
);

  localparam int unsigned CntW = $clog2(MaxExCycles + 1);

  typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             md_q, div_q;
  logic [4:0]       tag_q;
  logic [31:0]      wb_result_q;
  logic [4:0]       wb_tag_q;
  logic [1:0][33:0] imd_q;

  logic in_exec, issue_ready, accept, capture, expire, mult_sel, div_sel;

  // Reset masks readiness so nothing is offered while the block is being cleared.
  assign issue_ready = ~rst_i & ~bus.flush_i &
                       ((state_q == StIdle) | ((state_q == StWb) & bus.wb_ready_i));
  assign accept      = bus.issue_valid_i & issue_ready;
  assign in_exec     = (state_q == StExec);
  assign capture     = in_exec & bus.ex_valid_i & ~bus.flush_i;
  // Fires in the last allowed EXEC cycle, so EXEC never exceeds MaxExCycles cycles.
  assign expire      = in_exec & ~bus.ex_valid_i & ~bus.flush_i &
                       (cnt_q == CntW'(MaxExCycles - 1));

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush beats every other event.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StExec;
      end
      StExec: begin
        if (bus.flush_i || expire) state_d = StIdle;
        else if (capture)          state_d = StWb;
      end
      StWb: begin
        if (bus.flush_i)         state_d = StIdle;
        else if (bus.wb_ready_i) state_d = accept ? StExec : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    mult_sel                    = in_exec & md_q & ~div_q;
    div_sel                     = in_exec & md_q & div_q;
    bus.issue_ready_o           = issue_ready;
    // Staying in EXEC always bumps the counter, so zero marks the first cycle.
    bus.alu_instr_first_cycle_o = in_exec & (cnt_q == '0);
    bus.mult_sel_o              = mult_sel;
    bus.div_sel_o               = div_sel;
    bus.mult_en_o               = mult_sel & ~bus.flush_i;
    bus.div_en_o                = div_sel & ~bus.flush_i;
    bus.multdiv_ready_id_o      = in_exec;
    bus.wb_valid_o              = (state_q == StWb);
    bus.timeout_o               = expire;
  end

  assign bus.wb_result_o = wb_result_q;
  assign bus.wb_tag_o    = wb_tag_q;
  assign bus.imd_val_q_o = imd_q;

  // Watchdog: cleared on issue, counts EXEC cycles without a result, saturates.
  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = '0;
    end else if (in_exec && !bus.ex_valid_i && (cnt_q != CntW'(MaxExCycles))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      md_q        <= 1'b0;
      div_q       <= 1'b0;
      tag_q       <= '0;
      wb_result_q <= '0;
      wb_tag_q    <= '0;
      imd_q       <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) begin
        md_q  <= MultDivEn & bus.issue_md_i;
        div_q <= bus.issue_div_i;
        tag_q <= bus.issue_tag_i;
      end
      if (capture) begin
        wb_result_q <= bus.result_ex_i;
        wb_tag_q    <= tag_q;
      end
      // Intermediate writes land even in a flushed cycle.
      if (in_exec) begin
        for (int k = 0; k < 2; k++) begin
          if (bus.imd_val_we_i[k]) imd_q[k] <= bus.imd_val_d_i[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_ibex_ex_issue_ctrl.sv
// Testbench for ibex_ex_issue_ctrl: directed scenarios followed by random traffic, all
// checked cycle by cycle against a transaction-level model (in-flight flag + age, and a
// writeback queue).
module tb_ibex_ex_issue_ctrl;

  localparam int Max = 40;
  localparam bit Mde = 1'b1;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  tag;
  } wb_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ibex_ex_issue_ctrl_if bus ();

  ibex_ex_issue_ctrl #(
    .MultDivEn   (Mde),
    .MaxExCycles (Max)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Stimulus for the next cycle
  bit          s_rst, s_iv, s_md, s_div, s_flush, s_exv, s_wbr;
  logic [4:0]  s_tag;
  logic [31:0] s_res;
  logic [1:0]  s_we;
  logic [33:0] s_d0, s_d1;

  // Reference model
  bit          m_inflight;
  int          m_age, m_lat;
  bit          m_md, m_div;
  logic [4:0]  m_tag;
  logic [33:0] m_imd [2];
  wb_t         wbq [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_stim();
    s_rst = 0; s_iv = 0; s_md = 0; s_div = 0; s_flush = 0; s_exv = 0; s_wbr = 0;
    s_tag = '0; s_res = '0; s_we = '0; s_d0 = '0; s_d1 = '0;
  endtask

  // Drive one cycle, compare all outputs with the model, then advance the model.
  // Returns shortly after the falling edge so callers can add cycle-specific checks.
  task automatic cycle();
    bit e_ready, e_msel, e_dsel, acc;
    @(negedge clk);
    rst               = s_rst;
    bus.issue_valid_i = s_iv;
    bus.issue_md_i    = s_md;
    bus.issue_div_i   = s_div;
    bus.issue_tag_i   = s_tag;
    bus.flush_i       = s_flush;
    bus.ex_valid_i    = s_exv;
    bus.result_ex_i   = s_res;
    bus.imd_val_we_i  = s_we;
    bus.imd_val_d_i   = {s_d1, s_d0};
    bus.wb_ready_i    = s_wbr;
    #1;
    e_ready = !s_rst && !s_flush && !m_inflight && (wbq.size() == 0 || s_wbr);
    e_msel  = m_inflight && m_md && !m_div;
    e_dsel  = m_inflight && m_md && m_div;
    if (!s_rst) begin
      check_eq("issue_ready", bus.issue_ready_o, e_ready);
      check_eq("first_cycle", bus.alu_instr_first_cycle_o, m_inflight && m_age == 0);
      check_eq("mult_sel", bus.mult_sel_o, e_msel);
      check_eq("div_sel", bus.div_sel_o, e_dsel);
      check_eq("mult_en", bus.mult_en_o, e_msel && !s_flush);
      check_eq("div_en", bus.div_en_o, e_dsel && !s_flush);
      check_eq("md_ready", bus.multdiv_ready_id_o, m_inflight);
      check_eq("wb_valid", bus.wb_valid_o, wbq.size() != 0);
      check_eq("timeout", bus.timeout_o,
               m_inflight && !s_exv && !s_flush && m_age == Max - 1);
      check_eq("imd0", bus.imd_val_q_o[0], m_imd[0]);
      check_eq("imd1", bus.imd_val_q_o[1], m_imd[1]);
      if (wbq.size() != 0) begin
        check_eq("wb_result", bus.wb_result_o, wbq[0].res);
        check_eq("wb_tag", bus.wb_tag_o, wbq[0].tag);
      end
    end
    acc = s_iv && e_ready;
    if (s_rst) begin
      m_inflight = 0; m_age = 0; m_md = 0; m_div = 0; m_tag = '0;
      m_imd[0] = '0; m_imd[1] = '0;
      wbq.delete();
    end else begin
      if (m_inflight) begin
        if (s_we[0]) m_imd[0] = s_d0;
        if (s_we[1]) m_imd[1] = s_d1;
      end
      if (s_flush) begin
        m_inflight = 0;
        wbq.delete();
      end else begin
        if (m_inflight) begin
          if (s_exv) begin
            wbq.push_back({s_res, m_tag});
            m_inflight = 0;
          end else if (m_age == Max - 1) begin
            m_inflight = 0;
          end else begin
            m_age++;
          end
        end else if (wbq.size() != 0 && s_wbr) begin
          void'(wbq.pop_front());
        end
        if (acc) begin
          m_inflight = 1; m_age = 0;
          m_md = Mde && s_md; m_div = s_div; m_tag = s_tag;
          m_lat = ($urandom_range(0, 7) == 0) ? int'($urandom_range(36, 44))
                                              : int'($urandom_range(0, 4));
        end
      end
    end
  endtask

  initial begin
    int n, got, n_to;
    logic [31:0] res;
    logic [33:0] last0, last1;
    m_inflight = 0; m_age = 0; m_lat = 0; m_md = 0; m_div = 0; m_tag = '0;
    m_imd[0] = '0; m_imd[1] = '0;

    // Reset, then the idle state
    idle_stim(); s_rst = 1; s_we = 2'b11; s_d0 = '1; s_d1 = '1;
    cycle(); cycle();
    idle_stim(); cycle();
    check_eq("rst_ready", bus.issue_ready_o, 1);
    check_eq("rst_wb_result", bus.wb_result_o, 0);
    check_eq("rst_wb_tag", bus.wb_tag_o, 0);
    check_eq("rst_imd", bus.imd_val_q_o, 0);

    // ALU op, tag 5, result in first EXEC cycle
    idle_stim(); s_iv = 1; s_tag = 5; cycle();
    idle_stim(); s_exv = 1; s_res = 32'h1234; cycle();
    check_eq("alu_first", bus.alu_instr_first_cycle_o, 1);
    // Writeback stalled 3 cycles with a divide pending
    idle_stim(); s_iv = 1; s_md = 1; s_div = 1; s_tag = 9;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("stall_valid", bus.wb_valid_o, 1);
      check_eq("stall_result", bus.wb_result_o, 32'h1234);
      check_eq("stall_tag", bus.wb_tag_o, 5);
      check_eq("stall_ready", bus.issue_ready_o, 0);
    end
    s_wbr = 1; cycle();
    check_eq("release_ready", bus.issue_ready_o, 1);

    // Divide: result after 37 EXEC cycles, intermediate writes alternating
    n = 0; res = $urandom; last0 = '0; last1 = '0;
    for (int i = 1; i <= 37; i++) begin
      idle_stim();
      s_we = (i % 2 == 1) ? 2'b01 : 2'b10;
      s_d0 = {2'($urandom), 32'($urandom)};
      s_d1 = {2'($urandom), 32'($urandom)};
      if (s_we[0]) last0 = s_d0;
      if (s_we[1]) last1 = s_d1;
      s_exv = (i == 37); s_res = res;
      cycle();
      if (bus.div_en_o) n++;
    end
    check_eq("div_en_cycles", n, 37);
    idle_stim(); s_wbr = 1; cycle();
    check_eq("div_wb_valid", bus.wb_valid_o, 1);
    check_eq("div_wb_result", bus.wb_result_o, res);
    check_eq("div_wb_tag", bus.wb_tag_o, 9);
    check_eq("div_imd0", bus.imd_val_q_o[0], last0);
    check_eq("div_imd1", bus.imd_val_q_o[1], last1);
    idle_stim(); cycle();
    check_eq("div_one_wb", bus.wb_valid_o, 0);

    // Multiply flushed in its fourth EXEC cycle
    idle_stim(); s_iv = 1; s_md = 1; s_tag = 3; cycle();
    for (int i = 1; i <= 4; i++) begin
      idle_stim(); s_flush = (i == 4); cycle();
      if (i == 4) begin
        check_eq("flush_mult_en", bus.mult_en_o, 0);
        check_eq("flush_mult_sel", bus.mult_sel_o, 1);
      end
    end
    for (int i = 0; i < 3; i++) begin
      idle_stim(); s_wbr = 1; s_exv = 1; cycle();
      check_eq("flush_no_wb", bus.wb_valid_o, 0);
      check_eq("flush_idle", bus.multdiv_ready_id_o, 0);
    end

    // Watchdog with no result ever
    idle_stim(); s_iv = 1; s_tag = 7; cycle();
    got = 0; n_to = 0;
    for (int i = 1; i <= 45; i++) begin
      idle_stim(); cycle();
      if (bus.timeout_o) begin
        n_to++;
        if (got == 0) got = i;
      end
    end
    check_eq("timeout_cycle", got, Max);
    check_eq("timeout_pulses", n_to, 1);
    check_eq("timeout_idle", bus.issue_ready_o, 1);

    // Reset while holding a result in writeback
    idle_stim(); s_iv = 1; s_tag = 2; cycle();
    idle_stim(); s_exv = 1; s_res = 32'hdead_beef; cycle();
    idle_stim(); cycle();
    check_eq("pre_rst_wb", bus.wb_valid_o, 1);
    idle_stim(); s_rst = 1; cycle();
    idle_stim(); cycle();
    check_eq("post_rst_wb", bus.wb_valid_o, 0);
    check_eq("post_rst_ready", bus.issue_ready_o, 1);
    check_eq("post_rst_result", bus.wb_result_o, 0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      s_rst   = ($urandom_range(0, 255) == 0);
      s_iv    = 1'($urandom);
      s_md    = 1'($urandom);
      s_div   = 1'($urandom);
      s_tag   = 5'($urandom);
      s_flush = ($urandom_range(0, 15) == 0);
      s_exv   = m_inflight ? (m_age == m_lat) : 1'($urandom);
      s_res   = $urandom;
      s_we    = 2'($urandom);
      s_d0    = {2'($urandom), 32'($urandom)};
      s_d1    = {2'($urandom), 32'($urandom)};
      s_wbr   = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
